// File: rtl/rr_mux4_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin mux arbiter.
package rr_mux4_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
        onehot4 = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/rr_mux4_if.sv
// Requester/consumer bundle of the round-robin mux arbiter; master is the arbiter side.
interface rr_mux4_if #(parameter int WIDTH = 8);
    import rr_mux4_pkg::*;

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       last;
    logic [N_REQ*WIDTH-1:0] in_data;
    logic                   out_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [N_REQ-1:0]       gnt;
    logic [SEL_W-1:0]       sel;
    logic [3:0]             beat_cnt;

    modport master (
        input  req, last, in_data, out_ready,
        output out_valid, out_data, gnt, sel, beat_cnt
    );

    modport slave (
        output req, last, in_data, out_ready,
        input  out_valid, out_data, gnt, sel, beat_cnt
    );

endinterface

// File: rtl/rr_mux4_arbiter_pick.sv
// Rotating priority picker: first set request searching from start upward, modulo 4.
module rr_pick4
    import rr_mux4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;

    always_comb begin
        dbl = {req, req};
        rot = dbl[start +: N_REQ];
        off = '0;
        // Scan from the top so the lowest rotated index wins.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rot[N_REQ-1-i]) off = SEL_W'(N_REQ-1-i);
        end
        any = |req;
        idx = start + off;
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin owner of a 4:1 data mux; holds each grant for a valid/ready burst.
module rr_mux4_arbiter
    import rr_mux4_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    rr_mux4_if.master  bus
);

    logic [0:0]       state;
    logic [N_REQ-1:0] gnt_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr_q;
    logic [3:0]       cnt_q;

    logic             owner_req;
    logic             owner_last;
    logic             valid;
    logic             xfer;
    logic             cap_hit;
    logic             rel;
    logic [N_REQ-1:0] pick_req;
    logic [SEL_W-1:0] pick_start;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;

    always_comb begin
        owner_req  = bus.req[sel_q];
        owner_last = bus.last[sel_q];
        valid      = (state == BUSY) && owner_req;
        xfer       = valid && bus.out_ready;
        cap_hit    = ({1'b0, cnt_q} + 5'd1) == 5'(MAX_BURST);
        rel        = (state == BUSY) && (!owner_req || (xfer && (owner_last || cap_hit)));
        pick_req   = bus.req;
        if (rel && !owner_req) pick_req[sel_q] = 1'b0;
        // While busy the search always starts just past the owner, so a
        // persistent sole requester wraps back onto itself.
        pick_start = (state == BUSY) ? sel_q + SEL_W'(1) : ptr_q;
    end

    rr_pick4 u_pick (
        .req   (pick_req),
        .start (pick_start),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt_q <= '0;
            sel_q <= '0;
            cnt_q <= '0;
            ptr_q <= '0;
        end else if (state == IDLE) begin
            if (pick_any) begin
                state <= BUSY;
                gnt_q <= onehot4(pick_idx);
                sel_q <= pick_idx;
                cnt_q <= '0;
            end
        end else if (rel) begin
            ptr_q <= sel_q + SEL_W'(1);
            cnt_q <= '0;
            if (pick_any) begin
                gnt_q <= onehot4(pick_idx);
                sel_q <= pick_idx;
            end else begin
                state <= IDLE;
                gnt_q <= '0;
            end
        end else if (xfer) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    always_comb begin
        bus.out_valid = valid;
        bus.out_data  = valid ? bus.in_data[sel_q*WIDTH +: WIDTH] : '0;
        bus.gnt       = gnt_q;
        bus.sel       = sel_q;
        bus.beat_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Randomised and directed checks of rr_mux4_arbiter against a behavioural owner/ptr model.
module tb_rr_mux4_arbiter;

    localparam int W  = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_mux4_if #(.WIDTH(W)) bus ();

    rr_mux4_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: owner index (-1 when idle), beats in grant, search pointer.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;
    bit en      = 1'b0;
    bit m_xf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_cnt   = 0;
            m_ptr   = 0;
            en      = 1'b1;
        end else if (m_owner < 0) begin
            m_owner = first_from(bus.req, m_ptr);
            m_cnt   = 0;
        end else begin
            m_xf = bus.req[m_owner] && bus.out_ready;
            if (!bus.req[m_owner] || (m_xf && (bus.last[m_owner] || m_cnt + 1 == MB))) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = first_from(bus.req, m_ptr);
                m_cnt   = 0;
            end else if (m_xf) begin
                m_cnt++;
            end
        end
    end

    logic       e_valid;
    logic [3:0] e_gnt;
    logic [7:0] e_data;

    always @(negedge clk) begin
        if (en) begin
            e_valid = (m_owner >= 0) && bus.req[m_owner];
            e_gnt   = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
            e_data  = e_valid ? bus.in_data[m_owner*W +: W] : 8'h00;
            check("m_gnt", 32'(bus.gnt), 32'(e_gnt));
            check("m_valid", 32'(bus.out_valid), 32'(e_valid));
            check("m_data", 32'(bus.out_data), 32'(e_data));
            check("m_beat_cnt", 32'(bus.beat_cnt), 32'(m_cnt));
            check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            if (m_owner >= 0) check("m_sel", 32'(bus.sel), 32'(m_owner));
        end
    end

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        adv();
        rst = 1'b0;
    endtask

    logic [3:0] rot_exp [5];

    initial begin
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst           = 1'b1;
        bus.req       = 4'b1111;
        bus.last      = 4'b0000;
        bus.out_ready = 1'b1;
        bus.in_data   = 32'h44332211;

        // Reset with all requests held.
        adv();
        adv();
        @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_beat", 32'(bus.beat_cnt), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        adv();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("lat_gnt0", 32'(bus.gnt), 32'd0);
        adv();
        @(negedge clk);
        check("first_gnt", 32'(bus.gnt), 32'b0001);
        check("first_data", 32'(bus.out_data), 32'h11);

        // Rotation, one beat per grant.
        adv();
        do_reset();
        bus.req = 4'b1111; bus.last = 4'b1111; bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            adv();
            @(negedge clk);
            check("rot_gnt", 32'(bus.gnt), 32'(rot_exp[i]));
        end

        // Burst cap on a sole requester.
        adv();
        do_reset();
        bus.req = 4'b0100; bus.last = 4'b0000; bus.out_ready = 1'b1;
        bus.in_data = 32'h00A50000;
        for (int k = 0; k < 4; k++) begin
            adv();
            @(negedge clk);
            check("cap_beat", 32'(bus.beat_cnt), 32'(k));
            check("cap_data", 32'(bus.out_data), 32'hA5);
        end
        adv();
        @(negedge clk);
        check("cap_regnt", 32'(bus.gnt), 32'b0100);
        check("cap_beat0", 32'(bus.beat_cnt), 32'd0);

        // Backpressure on owner 1.
        adv();
        do_reset();
        bus.req = 4'b0010; bus.out_ready = 1'b0; bus.in_data = 32'h00003C00;
        adv();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data", 32'(bus.out_data), 32'h3C);
            check("bp_beat", 32'(bus.beat_cnt), 32'd0);
            check("bp_gnt", 32'(bus.gnt), 32'b0010);
            adv();
        end
        bus.out_ready = 1'b1;
        adv();
        @(negedge clk);
        check("bp_xfer_beat", 32'(bus.beat_cnt), 32'd1);

        // Owner 3 abandons with requester 0 waiting.
        adv();
        do_reset();
        bus.req = 4'b1000; bus.out_ready = 1'b0;
        adv();
        bus.req = 4'b0001;
        adv();
        @(negedge clk);
        check("ab_gnt0", 32'(bus.gnt), 32'b0001);

        // Owner 1 abandons to idle; pointer must advance to 2.
        adv();
        do_reset();
        bus.req = 4'b0010;
        adv();
        bus.req = 4'b0000;
        adv();
        @(negedge clk);
        check("ab_idle", 32'(bus.gnt), 32'd0);
        adv();
        bus.req = 4'b1111;
        adv();
        @(negedge clk);
        check("ab_ptr", 32'(bus.gnt), 32'b0100);

        // Reset in the middle of a burst.
        adv();
        do_reset();
        bus.req = 4'b0010; bus.last = 4'b0000; bus.out_ready = 1'b1;
        adv();
        adv();
        adv();
        rst = 1'b1;
        @(negedge clk);
        check("mid_beat2", 32'(bus.beat_cnt), 32'd2);
        adv();
        rst = 1'b0;
        bus.req = 4'b0110;
        @(negedge clk);
        check("mid_gnt", 32'(bus.gnt), 32'd0);
        check("mid_beat", 32'(bus.beat_cnt), 32'd0);
        adv();
        @(negedge clk);
        check("mid_regnt", 32'(bus.gnt), 32'b0010);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            adv();
            rst = ($urandom_range(0, 99) == 0);
            for (int b = 0; b < 4; b++) begin
                bus.req[b]  = ($urandom_range(0, 99) < 80);
                bus.last[b] = ($urandom_range(0, 99) < 25);
            end
            bus.out_ready = ($urandom_range(0, 99) < 70);
            bus.in_data   = $urandom();
        end
        adv();
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
